tile_match_ctrl: RTL and testbench

TILE_MATCH_CTRL -- requirements
Module: tile_match_ctrl

---
 rtl/tile_pkg.sv | 19 +
 rtl/tile_match_ctrl_hold_timer.sv | 35 +++
 rtl/tile_match_ctrl.sv | 155 +++++++++++++++
 tb/tb_tile_match_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// tile_pkg -- shared definitions for the tile matching game controller.
//   NUM_TILES : default board size in tiles (even)
//   SYM_W     : default symbol width per tile
//   MOVES_W   : width of the completed-attempt counter
//   state_e   : controller FSM states
package tile_pkg;
  localparam int NUM_TILES = 10;
  localparam int SYM_W     = 3;
  localparam int MOVES_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    PICK1,
    PICK2,
    COMPARE,
    HOLD,
    DONE
  } state_e;
endpackage

// File: rtl/tile_match_ctrl_hold_timer.sv
// hold_timer -- down-counter that times the mismatch display window.
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset
//   load_i  : preload so that done_o rises after HOLD_CYCLES counting cycles
//   count_i : decrement enable
//   done_o  : high when the count has reached zero
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  // done is sampled in the same cycle as the count, so the last counting
  // cycle is the one that sees zero: preload with HOLD_CYCLES-1.
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                        cnt_d = LOAD_VAL;
    else if (count_i && cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/tile_match_ctrl.sv
// tile_match_ctrl -- memory/pairs game controller.
//   CLOCK_50       : clock (rising edge)
//   reset          : synchronous active-high reset
//   start          : new game request (honoured in IDLE/DONE only)
//   board_sym      : symbol per tile, tile i at [i*SYM_W +: SYM_W]
//   sel_valid/sel_tile/sel_ready : tile pick handshake
//   revealed       : face-up mask
//   matched        : permanently matched mask
//   moves          : completed pair attempts, saturating
//   match_pulse / mismatch_pulse : one-cycle result strobes
//   game_over      : high in DONE
module tile_match_ctrl #(
  parameter int NUM_TILES   = tile_pkg::NUM_TILES,
  parameter int SYM_W       = tile_pkg::SYM_W,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_TILES*SYM_W-1:0]   board_sym,
  input  logic                         sel_valid,
  input  logic [3:0]                   sel_tile,
  output logic                         sel_ready,
  output logic [NUM_TILES-1:0]         revealed,
  output logic [NUM_TILES-1:0]         matched,
  output logic [tile_pkg::MOVES_W-1:0] moves,
  output logic                         match_pulse,
  output logic                         mismatch_pulse,
  output logic                         game_over
);
  import tile_pkg::*;

  state_e                          state_q, state_d;
  logic [NUM_TILES-1:0][SYM_W-1:0] sym_q;
  logic [3:0]                      pick1_q, pick1_d, pick2_q, pick2_d;
  logic [NUM_TILES-1:0]            revealed_q, revealed_d, matched_q, matched_d;
  logic [MOVES_W-1:0]              moves_q, moves_d;
  logic                            match_q, match_d, mismatch_q, mismatch_d;

  logic                 tile_ok, take_pick, start_ok, sym_eq, all_matched;
  logic                 hold_load, hold_cnt, hold_done;
  logic [NUM_TILES-1:0] pair_mask;

  // Pick qualification; the range test short-circuits the matched lookup.
  assign tile_ok   = ({1'b0, sel_tile} < 5'(NUM_TILES));
  assign take_pick = sel_valid && sel_ready && tile_ok && !matched_q[sel_tile] &&
                     !(state_q == PICK2 && sel_tile == pick1_q);
  assign start_ok  = start && (state_q == IDLE || state_q == DONE);

  // Compare against the board captured at start, never the live input.
  assign sym_eq      = (sym_q[pick1_q] == sym_q[pick2_q]);
  assign pair_mask   = (NUM_TILES'(1) << pick1_q) | (NUM_TILES'(1) << pick2_q);
  assign all_matched = &(matched_q | pair_mask);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)     state_d = PICK1;
      PICK1:      if (take_pick) state_d = PICK2;
      PICK2:      if (take_pick) state_d = COMPARE;
      COMPARE: begin
        if (!sym_eq)          state_d = HOLD;
        else if (all_matched) state_d = DONE;
        else                  state_d = PICK1;
      end
      HOLD:       if (hold_done) state_d = PICK1;
      default:    state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    sel_ready = (state_q == PICK1) || (state_q == PICK2);
    game_over = (state_q == DONE);
    hold_load = (state_q == COMPARE) && !sym_eq;
    hold_cnt  = (state_q == HOLD);
  end

  // Board / mask / counter next state
  always_comb begin
    revealed_d = revealed_q;
    matched_d  = matched_q;
    moves_d    = moves_q;
    pick1_d    = pick1_q;
    pick2_d    = pick2_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    if (start_ok) begin
      revealed_d = '0;
      matched_d  = '0;
      moves_d    = '0;
      pick1_d    = '0;
      pick2_d    = '0;
    end
    if (take_pick) begin
      revealed_d[sel_tile] = 1'b1;
      if (state_q == PICK1) pick1_d = sel_tile;
      else                  pick2_d = sel_tile;
    end
    if (state_q == COMPARE) begin
      if (moves_q != '1) moves_d = moves_q + MOVES_W'(1);
      if (sym_eq) begin
        matched_d = matched_q | pair_mask;
        match_d   = 1'b1;
      end else begin
        mismatch_d = 1'b1;
      end
    end
    // Only the mismatched pair flips back; matched tiles never sit in HOLD.
    if (state_q == HOLD && hold_done) revealed_d = revealed_q & ~pair_mask;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sym_q      <= '0;
      revealed_q <= '0;
      matched_q  <= '0;
      moves_q    <= '0;
      pick1_q    <= '0;
      pick2_q    <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      if (start_ok) sym_q <= board_sym;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      moves_q    <= moves_d;
      pick1_q    <= pick1_d;
      pick2_q    <= pick2_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
    end
  end

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .load_i  (hold_load),
    .count_i (hold_cnt),
    .done_o  (hold_done)
  );

  assign revealed       = revealed_q;
  assign matched        = matched_q;
  assign moves          = moves_q;
  assign match_pulse    = match_q;
  assign mismatch_pulse = mismatch_q;
endmodule

// File: tb/tb_tile_match_ctrl.sv
// Directed bench for tile_match_ctrl with a result scoreboard.
module tb_tile_match_ctrl;
  localparam int NT = 10;
  localparam int SW = 3;
  localparam int HC = 4;

  logic             clk = 1'b0;
  logic             reset, start, sel_valid;
  logic [3:0]       sel_tile;
  logic [NT*SW-1:0] board_sym;
  logic             sel_ready, match_pulse, mismatch_pulse, game_over;
  logic [NT-1:0]    revealed, matched;
  logic [7:0]       moves;

  typedef struct {
    bit            is_m;
    logic [7:0]    mv;
    logic [NT-1:0] mt;
  } exp_t;
  exp_t sb[$];

  int            n_chk = 0;
  int            n_err = 0;
  logic [SW-1:0] ref_sym [NT];
  logic [NT-1:0] exp_rev, exp_mat;
  logic [7:0]    exp_mv;

  tile_match_ctrl #(.NUM_TILES(NT), .SYM_W(SW), .HOLD_CYCLES(HC)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .start          (start),
    .board_sym      (board_sym),
    .sel_valid      (sel_valid),
    .sel_tile       (sel_tile),
    .sel_ready      (sel_ready),
    .revealed       (revealed),
    .matched        (matched),
    .moves          (moves),
    .match_pulse    (match_pulse),
    .mismatch_pulse (mismatch_pulse),
    .game_over      (game_over)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_board();
    for (int i = 0; i < NT; i++) board_sym[i*SW +: SW] = SW'(i / 2);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rev"},  32'(revealed), 32'(0));
    check({tag, "_mat"},  32'(matched), 32'(0));
    check({tag, "_mv"},   32'(moves), 32'(0));
    check({tag, "_rdy"},  32'(sel_ready), 32'(0));
    check({tag, "_go"},   32'(game_over), 32'(0));
    check({tag, "_pls"},  32'({match_pulse, mismatch_pulse}), 32'(0));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NT; i++) ref_sym[i] = board_sym[i*SW +: SW];
    exp_rev = '0;
    exp_mat = '0;
    exp_mv  = '0;
    check("start_rev", 32'(revealed), 32'(0));
    check("start_mat", 32'(matched), 32'(0));
    check("start_mv",  32'(moves), 32'(0));
    check("start_rdy", 32'(sel_ready), 32'(1));
    check("start_go",  32'(game_over), 32'(0));
  endtask

  task automatic first(input int a);
    sel_valid = 1'b1;
    sel_tile  = 4'(a);
    tick();
    sel_valid = 1'b0;
    exp_rev[a] = 1'b1;
    check("first_rev", 32'(revealed), 32'(exp_rev));
    check("first_rdy", 32'(sel_ready), 32'(1));
  endtask

  task automatic bad_pick(input int t);
    sel_valid = 1'b1;
    sel_tile  = 4'(t);
    tick();
    sel_valid = 1'b0;
    check("bad_rev", 32'(revealed), 32'(exp_rev));
    check("bad_rdy", 32'(sel_ready), 32'(1));
    check("bad_mv",  32'(moves), 32'(exp_mv));
    tick();
    check("bad_pls", 32'({match_pulse, mismatch_pulse}), 32'(0));
  endtask

  // Second pick, result strobe check, then HOLD walk on a mismatch.
  // poke_t >= 0 drives a pick on every HOLD cycle; rst_h > 0 resets on that HOLD cycle.
  task automatic second(input int a, input int b, input int poke_t, input int rst_h);
    exp_t e;
    bit   got, is_m;
    int   lat;
    is_m = (ref_sym[a] == ref_sym[b]);
    if (exp_mv != 8'hFF) exp_mv = exp_mv + 8'd1;
    if (is_m) begin
      exp_mat[a] = 1'b1;
      exp_mat[b] = 1'b1;
    end
    exp_rev[b] = 1'b1;
    sb.push_back('{is_m, exp_mv, exp_mat});
    sel_valid = 1'b1;
    sel_tile  = 4'(b);
    tick();
    sel_valid = 1'b0;
    check("cmp_rdy", 32'(sel_ready), 32'(0));
    got = 1'b0;
    lat = 1;
    for (int n = 0; n < 8 && !got; n++) begin
      tick();
      lat++;
      got = match_pulse | mismatch_pulse;
    end
    check("strobe_seen", 32'(got), 32'(1));
    e = sb.pop_front();
    check("latency",    32'(lat), 32'(2));
    check("match_pls",  32'(match_pulse), 32'(e.is_m));
    check("mism_pls",   32'(mismatch_pulse), 32'(!e.is_m));
    check("res_mv",     32'(moves), 32'(e.mv));
    check("res_mat",    32'(matched), 32'(e.mt));
    check("res_rev",    32'(revealed), 32'(exp_rev));
    if (is_m) begin
      check("res_go",  32'(game_over), 32'(&exp_mat));
      check("res_rdy", 32'(sel_ready), 32'(!(&exp_mat)));
      tick();
      check("match_once", 32'(match_pulse), 32'(0));
    end else begin
      for (int h = 1; h <= HC; h++) begin
        check("hold_rev", 32'(revealed), 32'(exp_rev));
        check("hold_rdy", 32'(sel_ready), 32'(0));
        check("hold_mv",  32'(moves), 32'(exp_mv));
        if (h > 1) check("mism_once", 32'(mismatch_pulse), 32'(0));
        if (h == rst_h) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          exp_rev = '0;
          exp_mat = '0;
          exp_mv  = '0;
          check_cleared("hold_rst");
          return;
        end
        if (poke_t >= 0) begin
          sel_valid = 1'b1;
          sel_tile  = 4'(poke_t);
        end
        tick();
      end
      sel_valid = 1'b0;
      exp_rev[a] = 1'b0;
      exp_rev[b] = 1'b0;
      check("post_hold_rev", 32'(revealed), 32'(exp_rev));
      check("post_hold_rdy", 32'(sel_ready), 32'(1));
      check("post_hold_mv",  32'(moves), 32'(exp_mv));
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    sel_valid = 1'b0;
    sel_tile  = '0;
    board_sym = '0;
    load_board();
    repeat (3) tick();
    check_cleared("reset");
    reset = 1'b0;
    // A pick in IDLE is not accepted.
    sel_valid = 1'b1;
    sel_tile  = 4'd0;
    tick();
    sel_valid = 1'b0;
    check_cleared("idle_pick");

    // Game 1: match, illegal picks, mismatch with pokes, finish the board.
    do_start();
    board_sym = '0;                  // live board changes must be ignored
    first(0); second(0, 1, -1, 0);
    check("g1_mat", 32'(matched), 32'(10'b0000000011));
    check("g1_mv",  32'(moves), 32'(1));
    bad_pick(12);
    bad_pick(0);
    first(3);
    bad_pick(3);
    bad_pick(12);
    bad_pick(1);
    start = 1'b1;                    // ignored outside IDLE/DONE
    tick();
    start = 1'b0;
    check("nostart_rev", 32'(revealed), 32'(exp_rev));
    check("nostart_mat", 32'(matched), 32'(exp_mat));
    check("nostart_rdy", 32'(sel_ready), 32'(1));
    second(3, 4, 9, 0);              // sym 1 vs 2 on the latched board
    for (int p = 1; p < NT / 2; p++) begin
      first(2 * p);
      second(2 * p, 2 * p + 1, -1, 0);
    end
    check("g1_go", 32'(game_over), 32'(1));
    check("g1_final_mv", 32'(moves), 32'(6));
    repeat (3) tick();
    check("g1_go_hold", 32'(game_over), 32'(1));

    // Game 2: five clean pairs.
    load_board();
    do_start();
    for (int p = 0; p < NT / 2; p++) begin
      first(2 * p);
      second(2 * p, 2 * p + 1, -1, 0);
    end
    check("g2_go",  32'(game_over), 32'(1));
    check("g2_mv",  32'(moves), 32'(5));
    check("g2_mat", 32'(matched), 32'(10'h3FF));
    do_start();

    // Reset on the second HOLD cycle: no flip-back, stays in IDLE.
    first(0); second(0, 2, -1, 2);
    repeat (6) begin
      tick();
      check_cleared("post_rst");
    end

    // Saturation of the move counter.
    do_start();
    for (int k = 0; k < 300; k++) begin
      first(0);
      second(0, 2, -1, 0);
    end
    check("sat_mv", 32'(moves), 32'(255));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
